puf_eval_ctrl: RTL and testbench

- Control stage around the 3-stage arbiter PUF delay line.
- Upstream, it accepts a challenge, drives the challenge and launch pulse into the delay line, and waits for the race.
- Downstream, it resolves which delay-line output rose first, repeats the race NUM_EVAL times and majority-votes the response bit.
- It returns the bit with a confidence count over a valid/ready handshake.

---
 rtl/puf_eval_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_puf_eval_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF evaluation controller: launches NUM_EVAL races per challenge and majority-votes the response.
// Optional race timeout enabled by defining PUF_TIMEOUT_EN.
module puf_eval_ctrl #(
  parameter int unsigned CHAL_W        = 3,
  parameter int unsigned NUM_EVAL      = 5,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned RACE_CYCLES   = 16,
  parameter int unsigned RELAX_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ichal_valid,
  output logic              ochal_ready,
  input  logic [CHAL_W-1:0] ichallange,
  output logic [CHAL_W-1:0] ochallange,
  output logic              opulse,
  input  logic              iout_1,
  input  logic              iout_2,
  output logic              oresp_valid,
  input  logic              iresp_ready,
  output logic              oresp,
  output logic [3:0]        oconf,
  output logic              otimeout,
  output logic              obusy
);

  localparam int unsigned MAX_SR  = (SETTLE_CYCLES > RELAX_CYCLES) ? SETTLE_CYCLES : RELAX_CYCLES;
  localparam int unsigned MAX_CYC = (RACE_CYCLES > MAX_SR) ? RACE_CYCLES : MAX_SR;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELAX_LAST  = CNT_W'(RELAX_CYCLES - 1);
`ifdef PUF_TIMEOUT_EN
  localparam logic [CNT_W-1:0] RACE_LAST   = CNT_W'(RACE_CYCLES - 1);
`endif
  localparam logic [3:0] EVAL_LAST = 4'(NUM_EVAL - 1);
  localparam logic [3:0] HALF      = 4'(NUM_EVAL / 2);
  localparam logic [3:0] NEVAL4    = 4'(NUM_EVAL);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LAUNCH,
    RELAX,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       ones, ones_nxt;
  logic [3:0]       evals, evals_nxt;
  logic             chal_load;
  logic             resp_load;
  logic [1:0]       sync_1, sync_2;
  logic             s1, s2;
`ifdef PUF_TIMEOUT_EN
  logic             timeout_set;
  logic             timeout_q;
`endif

  // Delay-line outputs are asynchronous; only the second flop is ever observed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= {sync_1[0], iout_1};
      sync_2 <= {sync_2[0], iout_2};
    end
  end

  assign s1 = sync_1[1];
  assign s2 = sync_2[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ones_nxt  = ones;
    evals_nxt = evals;
    chal_load = 1'b0;
    resp_load = 1'b0;
`ifdef PUF_TIMEOUT_EN
    timeout_set = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (ichal_valid) begin
          chal_load = 1'b1;
          cnt_nxt   = '0;
          ones_nxt  = '0;
          evals_nxt = '0;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (cnt == SETTLE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = LAUNCH;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LAUNCH: begin
        // A tie (both seen on the same cycle) falls through as a 0 vote.
        if (s1 || s2) begin
          if (s1 && !s2) ones_nxt = ones + 4'd1;
          cnt_nxt   = '0;
          state_nxt = RELAX;
        end
`ifdef PUF_TIMEOUT_EN
        else if (cnt == RACE_LAST) begin
          timeout_set = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = RELAX;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      RELAX: begin
        // Counter saturates so the exit also waits for both lines to fall.
        if (cnt == RELAX_LAST && !s1 && !s2) begin
          cnt_nxt   = '0;
          evals_nxt = evals + 4'd1;
          if (evals == EVAL_LAST) begin
            resp_load = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = SETUP;
          end
        end else if (cnt != RELAX_LAST) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        if (iresp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      ones        <= '0;
      evals       <= '0;
      ochallange  <= '0;
      opulse      <= 1'b0;
      oresp_valid <= 1'b0;
      oresp       <= 1'b0;
      oconf       <= '0;
    end else begin
      cnt         <= cnt_nxt;
      ones        <= ones_nxt;
      evals       <= evals_nxt;
      opulse      <= (state_nxt == LAUNCH);
      oresp_valid <= (state_nxt == DONE);
      if (chal_load) ochallange <= ichallange;
      if (resp_load) begin
        oresp <= (ones > HALF);
        oconf <= (ones > HALF) ? ones : (NEVAL4 - ones);
      end
    end
  end

`ifdef PUF_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              timeout_q <= 1'b0;
    else if (chal_load)   timeout_q <= 1'b0;
    else if (timeout_set) timeout_q <= 1'b1;
  end

  assign otimeout = timeout_q;
`else
  assign otimeout = 1'b0;
`endif

  assign ochal_ready = (state == IDLE);
  assign obusy       = (state != IDLE);

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Bench for puf_eval_ctrl: behavioural delay line, expected responses queued at challenge time.
module tb_puf_eval_ctrl;
  localparam int NEVAL  = 5;
  localparam int SETTLE = 4;
  localparam int RACE   = 16;
  localparam int RELAX  = 4;
  localparam int NEVER  = 1000;
  localparam int MINLAT = NEVAL * (SETTLE + 3 + RELAX) + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ichal_valid = 1'b0;
  logic       ochal_ready;
  logic [2:0] ichallange = '0;
  logic [2:0] ochallange;
  logic       opulse;
  logic       iout_1 = 1'b0;
  logic       iout_2 = 1'b0;
  logic       oresp_valid;
  logic       iresp_ready = 1'b0;
  logic       oresp;
  logic [3:0] oconf;
  logic       otimeout;
  logic       obusy;

  typedef struct {
    logic       resp;
    logic [3:0] conf;
    logic       to;
    int         pulses;
  } sb_t;

  sb_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  d1[NEVAL];
  int  d2[NEVAL];
  int  ri   = 0;
  int  lcnt = 0;
  int  plen = 0;

  puf_eval_ctrl #(
    .CHAL_W(3), .NUM_EVAL(NEVAL), .SETTLE_CYCLES(SETTLE),
    .RACE_CYCLES(RACE), .RELAX_CYCLES(RELAX)
  ) dut (
    .clk(clk), .rst(rst),
    .ichal_valid(ichal_valid), .ochal_ready(ochal_ready),
    .ichallange(ichallange), .ochallange(ochallange),
    .opulse(opulse), .iout_1(iout_1), .iout_2(iout_2),
    .oresp_valid(oresp_valid), .iresp_ready(iresp_ready),
    .oresp(oresp), .oconf(oconf), .otimeout(otimeout), .obusy(obusy)
  );

  always #5 clk = ~clk;

  // Delay line: output k rises d_k negedges into the pulse and falls with it.
  always @(negedge clk) begin
    if (rst || ochal_ready) begin
      iout_1 = 1'b0; iout_2 = 1'b0; lcnt = 0; ri = 0;
    end else if (opulse) begin
      lcnt++;
      iout_1 = (lcnt >= d1[(ri < NEVAL) ? ri : NEVAL-1]);
      iout_2 = (lcnt >= d2[(ri < NEVAL) ? ri : NEVAL-1]);
    end else begin
      if (lcnt > 0) begin plen = lcnt; ri++; end
      lcnt = 0; iout_1 = 1'b0; iout_2 = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_races(input int a0, b0, a1, b1, a2, b2, a3, b3, a4, b4);
    d1[0] = a0; d2[0] = b0; d1[1] = a1; d2[1] = b1; d1[2] = a2; d2[2] = b2;
    d1[3] = a3; d2[3] = b3; d1[4] = a4; d2[4] = b4;
  endtask

  function automatic sb_t model();
    sb_t e;
    int  ones = 0;
    e.to = 1'b0;
    for (int i = 0; i < NEVAL; i++) begin
      if (d1[i] >= NEVER && d2[i] >= NEVER) e.to = 1'b1;
      else if (d1[i] < d2[i]) ones++;
    end
    e.resp   = (ones > NEVAL / 2);
    e.conf   = 4'(e.resp ? ones : NEVAL - ones);
    e.pulses = NEVAL;
    return e;
  endfunction

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic start_txn(input logic [2:0] chal);
    int n = 0;
    while (!ochal_ready && n < 200) begin tick(); n++; end
    chk("ready_before_req", ochal_ready, 1);
    exp_q.push_back(model());
    ichal_valid = 1'b1;
    ichallange  = chal;
    tick();
    ichal_valid = 1'b0;
    ichallange  = ~chal;
    chk("chal_captured", ochallange, chal);
    chk("busy_after_req", obusy, 1);
    chk("ready_low_busy", ochal_ready, 0);
  endtask

  task automatic finish_txn(input logic [2:0] chal, input int hold);
    sb_t e;
    int  lat = 1;
    while (!oresp_valid && lat < 3000) begin
      tick(); lat++;
      if (obusy && ochallange !== chal) chk("chal_stable", ochallange, chal);
    end
    e = exp_q.pop_front();
    if (!oresp_valid) begin
      chk("resp_valid_wait", oresp_valid, 1);
      return;
    end
    chk("latency_min", (lat >= MINLAT), 1);
    chk("resp", oresp, e.resp);
    chk("conf", oconf, e.conf);
    chk("timeout", otimeout, e.to);
    chk("pulses", ri, e.pulses);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", oresp_valid, 1);
      chk("hold_resp", {oresp, oconf, otimeout}, {e.resp, e.conf, e.to});
      chk("hold_ready_low", ochal_ready, 0);
    end
    iresp_ready = 1'b1;
    tick();
    iresp_ready = 1'b0;
    chk("valid_drop", oresp_valid, 0);
    chk("ready_back", ochal_ready, 1);
    chk("busy_clear", obusy, 0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_pulse", opulse, 0);
    chk("rst_valid", oresp_valid, 0);
    chk("rst_idle", ochal_ready, 1);
    chk("rst_busy", obusy, 0);
    chk("rst_chal", ochallange, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    sb_t drop;
    int  n;
    set_races(1, 4, 1, 4, 1, 4, 1, 4, 1, 4);
    repeat (3) tick();
    chk("reset_ready", ochal_ready, 1);
    chk("reset_pulse", opulse, 0);
    chk("reset_valid", oresp_valid, 0);
    chk("reset_outs", {oresp, oconf, otimeout}, 0);
    chk("reset_chal", ochallange, 0);
    chk("reset_busy", obusy, 0);
    rst = 1'b0;
    tick();

    // iout_1 leads by 3 on every race, response held off for 10 cycles
    start_txn(3'b000);
    finish_txn(3'b000, 10);

    // iout_2 leads on 3 of 5
    set_races(4, 1, 1, 4, 4, 1, 1, 4, 4, 1);
    start_txn(3'b111);
    finish_txn(3'b111, 0);

    // all ties
    set_races(1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
    start_txn(3'b101);
    finish_txn(3'b101, 2);

    // four wins for iout_1 plus one tie
    set_races(1, 4, 2, 2, 1, 4, 1, 4, 2, 5);
    start_txn(3'b110);
    finish_txn(3'b110, 1);

    // reset during the third launch, then a clean run
    set_races(1, 4, 1, 4, 1, 4, 1, 4, 1, 4);
    start_txn(3'b010);
    n = 0;
    while (!(ri == 2 && opulse) && n < 500) begin tick(); n++; end
    chk("third_launch_reached", (ri == 2 && opulse), 1);
    do_reset();
    drop = exp_q.pop_front();
    chk("no_resp_after_rst", oresp_valid, 0);
    start_txn(3'b011);
    finish_txn(3'b011, 0);

    // delay line never answers
    set_races(NEVER, NEVER, NEVER, NEVER, NEVER, NEVER, NEVER, NEVER, NEVER, NEVER);
    start_txn(3'b100);
`ifdef PUF_TIMEOUT_EN
    finish_txn(3'b100, 1);
    chk("launch_len", plen, RACE);
`else
    repeat (80) tick();
    chk("stuck_busy", obusy, 1);
    chk("stuck_pulse", opulse, 1);
    chk("stuck_no_valid", oresp_valid, 0);
    do_reset();
    drop = exp_q.pop_front();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench time limit");
  end

endmodule
